inv_key_schedule: RTL and testbench

INV_KEY_SCHEDULE -- requirements
Module: inv_key_schedule

---
 rtl/inv_key_schedule_if.sv | 24 ++
 rtl/inv_key_schedule.sv | 135 +++++++++++++
 tb/tb_inv_key_schedule.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/inv_key_schedule_if.sv
// Handshake bundle for the inverse AES-128 key schedule: key load on the
// input side, round-key stream on the output side.
interface inv_key_schedule_if #(
  parameter int KEY_LENGTH = 128
);
  logic                  i_valid;
  logic                  i_ready;
  logic [KEY_LENGTH-1:0] key_in;
  logic                  o_valid;
  logic                  o_ready;
  logic [KEY_LENGTH-1:0] o_key;
  logic [3:0]            o_round;
  logic                  o_last;

  modport slave (
    input  i_valid, key_in, o_ready,
    output i_ready, o_valid, o_key, o_round, o_last
  );

  modport master (
    output i_valid, key_in, o_ready,
    input  i_ready, o_valid, o_key, o_round, o_last
  );
endinterface

// File: rtl/inv_key_schedule.sv
// Inverse AES-128 key schedule: given the final round key, walks backwards
// emitting round keys Nr..0, one per accepted output cycle.
module inv_key_schedule #(
  parameter int KEY_LENGTH  = 128,
  parameter int WORD_LENGTH = 32,
  parameter int Nr          = 10
) (
  input logic               clk,
  input logic               reset,
  inv_key_schedule_if.slave bus
);

  localparam logic [3:0] NR_IDX = 4'(Nr);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, EMIT} state_t;

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[a];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_t                state_q;
  logic [KEY_LENGTH-1:0] key_q;
  logic [3:0]            round_q;
  logic                  o_valid_q;
  logic                  i_ready_q;
  logic                  o_last_q;

  logic [WORD_LENGTH-1:0] w0, w1, w2, w3;
  logic [WORD_LENGTH-1:0] p0, p1, p2, p3;
  logic [WORD_LENGTH-1:0] rot_w;
  logic [7:0]             sb0, sb1, sb2, sb3;
  logic [KEY_LENGTH-1:0]  inv_key_d;

  assign w0 = key_q[4*WORD_LENGTH-1 -: WORD_LENGTH];
  assign w1 = key_q[3*WORD_LENGTH-1 -: WORD_LENGTH];
  assign w2 = key_q[2*WORD_LENGTH-1 -: WORD_LENGTH];
  assign w3 = key_q[WORD_LENGTH-1 -: WORD_LENGTH];

  // Undo the forward XOR chain; p3 is the previous round's w3, which feeds
  // the g() function that produced the current w0.
  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  assign rot_w = {p3[23:0], p3[31:24]};
  assign sb0   = sbox(rot_w[31:24]);
  assign sb1   = sbox(rot_w[23:16]);
  assign sb2   = sbox(rot_w[15:8]);
  assign sb3   = sbox(rot_w[7:0]);

  // Rcon is indexed by the round of the key currently held, not the target.
  assign p0        = w0 ^ {sb0, sb1, sb2, sb3} ^ {rcon(round_q), 24'h0};
  assign inv_key_d = {p0, p1, p2, p3};

  // Load/step FSM; every output comes straight from a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      key_q     <= '0;
      round_q   <= '0;
      o_valid_q <= 1'b0;
      i_ready_q <= 1'b1;
      o_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.i_valid) begin
            key_q     <= bus.key_in;
            round_q   <= NR_IDX;
            o_last_q  <= (NR_IDX == 4'd0);
            o_valid_q <= 1'b1;
            i_ready_q <= 1'b0;
            state_q   <= EMIT;
          end
        end
        EMIT: begin
          if (bus.o_ready) begin
            if (round_q != 4'd0) begin
              key_q    <= inv_key_d;
              round_q  <= round_q - 4'd1;
              o_last_q <= (round_q == 4'd1);
            end else begin
              o_valid_q <= 1'b0;
              i_ready_q <= 1'b1;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.i_ready = i_ready_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_key   = key_q;
  assign bus.o_round = round_q;
  assign bus.o_last  = o_last_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for the inverse key schedule using the FIPS-197 Appendix A.1
// expansion of key 2b7e1516... as the reference round keys.
module tb_inv_key_schedule;

  logic clk    = 1'b0;
  logic clk_en = 1'b0;
  logic reset  = 1'b0;

  int vectors    = 0;
  int miscompares = 0;

  logic [127:0] rk [0:10];
  logic [127:0] fips_key;
  logic [127:0] zero_src;

  inv_key_schedule_if #(.KEY_LENGTH(128)) bus ();

  inv_key_schedule #(
    .KEY_LENGTH (128),
    .WORD_LENGTH(32),
    .Nr         (10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 if (clk_en) clk = ~clk;

  task automatic start_walk(input logic [127:0] k);
    bus.i_valid = 1'b1;
    bus.key_in  = k;
    @(negedge clk);
    bus.i_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b1;
    #1;
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL reset_o_valid got %b want 0", bus.o_valid); end
    vectors++; if (bus.o_key !== 128'h0) begin miscompares++; $display("FAIL reset_o_key got %h want 0", bus.o_key); end
    vectors++; if (bus.o_round !== 4'd0) begin miscompares++; $display("FAIL reset_o_round got %0d want 0", bus.o_round); end
    vectors++; if (bus.o_last !== 1'b0) begin miscompares++; $display("FAIL reset_o_last got %b want 0", bus.o_last); end
    vectors++; if (bus.i_ready !== 1'b1) begin miscompares++; $display("FAIL reset_i_ready got %b want 1", bus.i_ready); end
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (bus.i_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_i_ready got %b want 1", bus.i_ready); end
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_o_valid got %b want 0", bus.o_valid); end
  endtask

  task automatic test_fips_walk(input string tag);
    bus.o_ready = 1'b1;
    start_walk(fips_key);
    for (int r = 10; r >= 0; r--) begin
      vectors++; if (bus.o_valid !== 1'b1) begin miscompares++; $display("FAIL %s_valid r=%0d got %b want 1", tag, r, bus.o_valid); end
      vectors++; if (bus.o_round !== 4'(r)) begin miscompares++; $display("FAIL %s_round got %0d want %0d", tag, bus.o_round, r); end
      vectors++; if (bus.o_key !== rk[r]) begin miscompares++; $display("FAIL %s_key r=%0d got %h want %h", tag, r, bus.o_key, rk[r]); end
      vectors++; if (bus.o_last !== (r == 0)) begin miscompares++; $display("FAIL %s_last r=%0d got %b want %b", tag, r, bus.o_last, (r == 0)); end
      vectors++; if (bus.i_ready !== 1'b0) begin miscompares++; $display("FAIL %s_busy_ready r=%0d got %b want 0", tag, r, bus.i_ready); end
      @(negedge clk);
    end
    vectors++; if (bus.i_ready !== 1'b1) begin miscompares++; $display("FAIL %s_end_ready got %b want 1", tag, bus.i_ready); end
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL %s_end_valid got %b want 0", tag, bus.o_valid); end
  endtask

  task automatic test_backpressure();
    bus.o_ready = 1'b1;
    start_walk(fips_key);
    for (int r = 10; r >= 0; r--) begin
      vectors++; if (bus.o_round !== 4'(r)) begin miscompares++; $display("FAIL bp_round got %0d want %0d", bus.o_round, r); end
      vectors++; if (bus.o_key !== rk[r]) begin miscompares++; $display("FAIL bp_key r=%0d got %h want %h", r, bus.o_key, rk[r]); end
      if (r == 9) begin
        bus.o_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          vectors++; if (bus.o_round !== 4'd9) begin miscompares++; $display("FAIL bp_hold_round got %0d want 9", bus.o_round); end
          vectors++; if (bus.o_key !== rk[9]) begin miscompares++; $display("FAIL bp_hold_key got %h want %h", bus.o_key, rk[9]); end
          vectors++; if (bus.o_valid !== 1'b1) begin miscompares++; $display("FAIL bp_hold_valid got %b want 1", bus.o_valid); end
        end
        bus.o_ready = 1'b1;
      end
      @(negedge clk);
    end
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL bp_end_valid got %b want 0", bus.o_valid); end
  endtask

  task automatic test_busy();
    bus.o_ready = 1'b1;
    start_walk(fips_key);
    for (int r = 10; r >= 0; r--) begin
      vectors++; if (bus.o_round !== 4'(r)) begin miscompares++; $display("FAIL busy_round got %0d want %0d", bus.o_round, r); end
      vectors++; if (bus.o_key !== rk[r]) begin miscompares++; $display("FAIL busy_key r=%0d got %h want %h", r, bus.o_key, rk[r]); end
      if (r == 6) begin
        bus.i_valid = 1'b1;
        bus.key_in  = 128'h00112233445566778899aabbccddeeff;
      end else begin
        bus.i_valid = 1'b0;
      end
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL busy_end_valid got %b want 0", bus.o_valid); end
    vectors++; if (bus.o_key !== rk[0]) begin miscompares++; $display("FAIL busy_idle_key got %h want %h", bus.o_key, rk[0]); end
  endtask

  task automatic test_midwalk_reset();
    bus.o_ready = 1'b1;
    start_walk(fips_key);
    repeat (5) @(negedge clk);
    vectors++; if (bus.o_round !== 4'd5) begin miscompares++; $display("FAIL mr_pre_round got %0d want 5", bus.o_round); end
    vectors++; if (bus.o_key !== rk[5]) begin miscompares++; $display("FAIL mr_pre_key got %h want %h", bus.o_key, rk[5]); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (bus.o_valid !== 1'b0) begin miscompares++; $display("FAIL mr_o_valid got %b want 0", bus.o_valid); end
    vectors++; if (bus.o_key !== 128'h0) begin miscompares++; $display("FAIL mr_o_key got %h want 0", bus.o_key); end
    vectors++; if (bus.o_round !== 4'd0) begin miscompares++; $display("FAIL mr_o_round got %0d want 0", bus.o_round); end
    vectors++; if (bus.i_ready !== 1'b1) begin miscompares++; $display("FAIL mr_i_ready got %b want 1", bus.i_ready); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    vectors++; if (bus.i_ready !== 1'b1) begin miscompares++; $display("FAIL mr_release_ready got %b want 1", bus.i_ready); end
    test_fips_walk("mr_walk");
  endtask

  task automatic test_back_to_back_zero_key();
    bus.o_ready = 1'b1;
    start_walk(zero_src);
    for (int r = 10; r >= 0; r--) begin
      vectors++; if (bus.o_round !== 4'(r)) begin miscompares++; $display("FAIL zk_round got %0d want %0d", bus.o_round, r); end
      if (r == 10) begin
        vectors++; if (bus.o_key !== zero_src) begin miscompares++; $display("FAIL zk_first_key got %h want %h", bus.o_key, zero_src); end
      end
      if (r == 0) begin
        vectors++; if (bus.o_key !== 128'h0) begin miscompares++; $display("FAIL zk_last_key got %h want 0", bus.o_key); end
        vectors++; if (bus.o_last !== 1'b1) begin miscompares++; $display("FAIL zk_last got %b want 1", bus.o_last); end
      end
      @(negedge clk);
    end
    vectors++; if (bus.i_ready !== 1'b1) begin miscompares++; $display("FAIL zk_end_ready got %b want 1", bus.i_ready); end
  endtask

  initial begin
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    fips_key = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    zero_src = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    bus.i_valid = 1'b0;
    bus.key_in  = '0;
    bus.o_ready = 1'b1;

    test_reset();
    test_fips_walk("fips");
    test_back_to_back_zero_key();
    test_backpressure();
    test_busy();
    test_midwalk_reset();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
